// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing a bank of 32-bit software-writable registers to fabric logic,
// with byte-enable writes, readback, update strobes and optional shadow/commit mode.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h0108E900,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108E9FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 8,
  parameter int          C_ATOMIC     = 0,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_update
);

  localparam logic [7:0] NREG8  = 8'(C_NUM_REGS);
  localparam logic       ATOMIC = (C_ATOMIC != 0);
  localparam logic [31:0] CTRL_WORD = {16'h0000, NREG8, 6'b000000, ATOMIC, 1'b0};

  logic [31:0] w_addr;
  logic [31:0] w_offset;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [7:0]  w_word;
  logic        w_hit;
  logic        w_start;
  logic [31:0] w_rd_val;
  logic        w_unused;

  logic [31:0]           r_out    [C_NUM_REGS];
  logic [31:0]           r_shadow [C_NUM_REGS];
  logic                  r_xfer_ack;
  logic [31:0]           r_rdata;
  logic [C_NUM_REGS-1:0] r_update;
  logic                  r_pend_wr;
  logic [7:0]            r_pend_word;
  logic [3:0]            r_pend_be;
  logic [31:0]           r_pend_data;
  logic                  r_commit_pending;

  // OPB bit 0 is the MSB, so plain assignment gives the user (little-endian) view.
  assign w_addr   = OPB_ABus;
  assign w_wdata  = OPB_DBus;
  assign w_be     = OPB_BE;
  assign w_offset = w_addr - C_BASEADDR;
  assign w_word   = w_offset[9:2];
  assign w_hit    = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
  assign w_start  = w_hit && !r_xfer_ack;
  assign w_unused = &{1'b0, OPB_seqAddr, w_offset[31:10], w_offset[1:0]};

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (w_word == 8'(i)) w_rd_val = ATOMIC ? r_shadow[i] : r_out[i];
    end
    if (w_word == NREG8) w_rd_val = CTRL_WORD;
  end

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // A hit is latched on the sampling edge and applied at the end of its ack cycle,
  // so a commit following a write always sees the updated shadow.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        r_out[i]    <= C_RESET_VAL;
        r_shadow[i] <= C_RESET_VAL;
      end
      r_xfer_ack       <= 1'b0;
      r_rdata          <= '0;
      r_update         <= '0;
      r_pend_wr        <= 1'b0;
      r_pend_word      <= '0;
      r_pend_be        <= '0;
      r_pend_data      <= '0;
      r_commit_pending <= 1'b0;
    end else begin
      r_xfer_ack <= w_start;
      r_rdata    <= (w_start && OPB_RNW) ? w_rd_val : '0;
      r_update   <= '0;
      if (w_start) begin
        r_pend_wr        <= !OPB_RNW;
        r_pend_word      <= w_word;
        r_pend_be        <= w_be;
        r_pend_data      <= w_wdata;
        r_commit_pending <= ATOMIC && !OPB_RNW && (w_word == NREG8) && w_be[0] && w_wdata[0];
      end else if (r_xfer_ack) begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (r_pend_wr && (r_pend_word == 8'(i))) begin
            if (ATOMIC) begin
              r_shadow[i] <= merge(r_shadow[i], r_pend_data, r_pend_be);
            end else begin
              r_out[i]    <= merge(r_out[i], r_pend_data, r_pend_be);
              r_update[i] <= 1'b1;
            end
          end
        end
        if (r_commit_pending) begin
          for (int i = 0; i < C_NUM_REGS; i++) r_out[i] <= r_shadow[i];
          r_update <= '1;
        end
        r_pend_wr        <= 1'b0;
        r_commit_pending <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = r_out[g];
  end

  assign user_update = r_update;
  assign Sl_DBus     = r_rdata;
  assign Sl_xferAck  = r_xfer_ack;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench driving a direct-mode and an atomic-mode bank from one shared OPB master.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h0108E900;
  localparam logic [31:0] HIGH = 32'h0108E9FF;

  logic        clk;
  logic        rst_n;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        sel;
  logic        seq;

  logic [0:31]  dbus0, dbus1;
  logic         err0, err1, rty0, rty1, tout0, tout1, ack0, ack1;
  logic [255:0] udo0, udo1;
  logic [7:0]   upd0, upd1;

  int n_checks = 0;
  int n_errors = 0;

  opb_register_bank_ppc2simulink #(.C_ATOMIC(0)) dut0 (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(dbus0),
    .Sl_errAck(err0), .Sl_retry(rty0), .Sl_toutSup(tout0), .Sl_xferAck(ack0),
    .user_data_out(udo0), .user_update(upd0));

  opb_register_bank_ppc2simulink #(.C_ATOMIC(1)) dut1 (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(dbus1),
    .Sl_errAck(err1), .Sl_retry(rty1), .Sl_toutSup(tout1), .Sl_xferAck(ack1),
    .user_data_out(udo1), .user_update(upd1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer: ack must appear exactly one cycle after select is sampled.
  task automatic xfer(input logic r, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd0, output logic [31:0] rd1,
                      output logic [7:0] u0, output logic [7:0] u1);
    @(negedge clk);
    sel = 1'b1; rnw = r; abus = a; be = b; dbus = d;
    @(posedge clk); #1;
    chk("ack0_latency", 256'(ack0), 256'(1'b1));
    chk("ack1_latency", 256'(ack1), 256'(1'b1));
    rd0 = dbus0; rd1 = dbus1;
    sel = 1'b0; rnw = 1'b1; be = 4'h0; dbus = '0;
    @(posedge clk); #1;
    chk("ack0_single", 256'(ack0), 256'(1'b0));
    chk("ack1_single", 256'(ack1), 256'(1'b0));
    u0 = upd0; u1 = upd1;
  endtask

  logic [31:0]  rd0, rd1;
  logic [7:0]   u0, u1;
  logic [255:0] e0, e1;

  initial begin
    rst_n = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b1; sel = 1'b0; seq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", 256'(ack0), 256'(1'b0));
    chk("rst_dbus1", 256'(dbus1), 256'h0);
    chk("rst_upd0", 256'(upd0), 256'h0);
    chk("rst_udo0", udo0, 256'h0);
    chk("rst_udo1", udo1, 256'h0);
    chk("tied_sigs", 256'({err0, rty0, tout0, err1, rty1, tout1}), 256'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int w = 0; w < 8; w++) begin
      xfer(1'b1, BASE + 32'(4*w), 4'hF, 32'h0, rd0, rd1, u0, u1);
      chk("rd_reset0", 256'(rd0), 256'h0);
      chk("rd_reset1", 256'(rd1), 256'h0);
      chk("rd_noupd", 256'({u0, u1}), 256'h0);
    end

    xfer(1'b0, BASE + 32'd8, 4'hF, 32'hDEADBEEF, rd0, rd1, u0, u1);
    chk("wr2_upd0", 256'(u0), 256'h04);
    chk("wr2_upd1", 256'(u1), 256'h00);
    chk("wr2_udo0", 256'(udo0[95:64]), 256'hDEADBEEF);
    chk("wr2_udo1", udo1, 256'h0);
    chk("wr2_nordata", 256'(rd0), 256'h0);
    xfer(1'b1, BASE + 32'd8, 4'hF, 32'h0, rd0, rd1, u0, u1);
    chk("rb2_0", 256'(rd0), 256'hDEADBEEF);
    chk("rb2_1", 256'(rd1), 256'hDEADBEEF);

    xfer(1'b0, BASE + 32'd8, 4'b0101, 32'h11223344, rd0, rd1, u0, u1);
    chk("be_udo0", 256'(udo0[95:64]), 256'hDE22BE44);
    xfer(1'b1, BASE + 32'd8, 4'hF, 32'h0, rd0, rd1, u0, u1);
    chk("be_rb0", 256'(rd0), 256'hDE22BE44);
    chk("be_rb1", 256'(rd1), 256'hDE22BE44);

    xfer(1'b0, BASE + 32'd0, 4'hF, 32'h5, rd0, rd1, u0, u1);
    chk("w0_upd0", 256'(u0), 256'h01);
    chk("w0_udo1_hold", udo1, 256'h0);
    xfer(1'b0, BASE + 32'd4, 4'hF, 32'h7, rd0, rd1, u0, u1);
    chk("w1_upd0", 256'(u0), 256'h02);
    chk("w1_upd1", 256'(u1), 256'h00);
    chk("w1_udo1_hold", udo1, 256'h0);
    xfer(1'b1, BASE + 32'd0, 4'hF, 32'h0, rd0, rd1, u0, u1);
    chk("sh0_rb1", 256'(rd1), 256'h5);
    xfer(1'b1, BASE + 32'd4, 4'hF, 32'h0, rd0, rd1, u0, u1);
    chk("sh1_rb1", 256'(rd1), 256'h7);

    e0 = '0; e0[31:0] = 32'h5; e0[63:32] = 32'h7; e0[95:64] = 32'hDE22BE44;
    chk("pre_commit_udo0", udo0, e0);
    xfer(1'b0, BASE + 32'd32, 4'hF, 32'h1, rd0, rd1, u0, u1);
    e1 = e0;
    chk("commit_upd1", 256'(u1), 256'hFF);
    chk("commit_udo1", udo1, e1);
    chk("commit_upd0", 256'(u0), 256'h00);
    chk("commit_udo0", udo0, e0);

    @(negedge clk);
    sel = 1'b1; rnw = 1'b0; abus = HIGH + 32'd4; be = 4'hF; dbus = 32'hFFFFFFFF;
    repeat (3) begin
      @(posedge clk); #1;
      chk("oow_ack", 256'({ack0, ack1}), 256'h0);
      chk("oow_dbus", 256'({dbus0, dbus1}), 256'h0);
    end
    sel = 1'b0;
    chk("oow_udo0", udo0, e0);
    chk("oow_udo1", udo1, e1);

    xfer(1'b1, BASE + 32'd32, 4'hF, 32'h0, rd0, rd1, u0, u1);
    chk("ctrl_rd1", 256'(rd1), 256'h802);
    chk("ctrl_rd0", 256'(rd0), 256'h800);

    xfer(1'b0, BASE + 32'd36, 4'hF, 32'hA5A5A5A5, rd0, rd1, u0, u1);
    chk("w9_noupd", 256'({u0, u1}), 256'h0);
    chk("w9_udo0", udo0, e0);
    xfer(1'b1, BASE + 32'd36, 4'hF, 32'h0, rd0, rd1, u0, u1);
    chk("w9_rd", 256'({rd0, rd1}), 256'h0);

    @(negedge clk);
    sel = 1'b1; rnw = 1'b0; abus = BASE + 32'd12; be = 4'hF; dbus = 32'h12345678; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_hit_ack", 256'({ack0, ack1}), 256'h0);
    sel = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_hit_noack", 256'({ack0, ack1}), 256'h0);
    chk("rst_hit_udo0", udo0, 256'h0);
    chk("rst_hit_udo1", udo1, 256'h0);
    xfer(1'b1, BASE + 32'd12, 4'hF, 32'h0, rd0, rd1, u0, u1);
    chk("rst_hit_rd", 256'({rd0, rd1}), 256'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
Parametrised successor to the single software-to-fabric register: a bank of C_NUM_REGS 32-bit PowerPC-writable registers behind one OPB slave window, driving the fabric through a single flattened bus. Adds byte-enable writes, full readback, per-register update strobes and an optional atomic (shadow/commit) mode so multi-word settings such as per-input quantiser gains change on the same cycle. Fabric logic runs on the OPB clock (single-clock variant).

Parameters:
C_BASEADDR, 32'h0108E900, window base, 256-byte aligned
C_HIGHADDR, 32'h0108E9FF, window top, inclusive
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width; only 32 supported
C_NUM_REGS, 8, number of user registers, 1..63
C_ATOMIC, 0, 1 = writes land in shadow registers, outputs update only on commit
C_RESET_VAL, 32'h00000000, reset value of every shadow and output register

Ports:
OPB_Clk  in  1  single clock for bus and fabric
OPB_Rst  in  1  synchronous, active-low reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[0] = DBus[0:7] = user bits 31:24
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data, zero when not acking
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  one-cycle transfer acknowledge
user_data_out  out  [32*C_NUM_REGS-1:0]  register i at bits [32i+31:32i]
user_update  out  [C_NUM_REGS-1:0]  one-cycle pulse, bit i when output register i changes source

Behaviour:
- Reset (OPB_Rst=0 at a rising edge): all shadow/output registers = C_RESET_VAL; Sl_xferAck=0, Sl_DBus=0, user_update=0, commit_pending=0. Reset overrides an in-flight transfer; no ack is issued for it.
- Hit = OPB_select && C_BASEADDR <= ABus <= C_HIGHADDR. Word index w = ABus[22:29] relative to base (byte offset >> 2).
- Ack: Sl_xferAck registered; asserted in the cycle after a hit is sampled, only if Sl_xferAck is currently 0. Exactly one ack per transfer, latency 1. Back-to-back transfers ack every other cycle at most.
- Write (RNW=0), w < C_NUM_REGS: on the ack cycle each byte with BE set replaces the corresponding byte of target register (shadow if C_ATOMIC=1, output otherwise). C_ATOMIC=0: user_update[w] pulses the following cycle (same cycle user_data_out shows new value).
- w == C_NUM_REGS: control word. Write with DBus[31]=1 (bit 0 of user view) and BE[3]=1 = commit: if C_ATOMIC=1 all shadows copy to outputs the next cycle, user_update pulses all-ones that cycle. C_ATOMIC=0: commit ignored. Read returns {C_NUM_REGS[7:0] in bits 15:8, C_ATOMIC in bit 1, 0 elsewhere}.
- w > C_NUM_REGS inside window: acked, write ignored, read 0.
- Read (RNW=1): Sl_DBus = shadow value (C_ATOMIC=1) or output value, driven only in the ack cycle; 0 otherwise. Read has no side effects.
- Write and commit to the same register in consecutive transfers: commit copies the already-updated shadow (write precedes commit by ack ordering).
- Outside window: no ack, no state change, Sl_DBus=0.
- Registers hold value indefinitely; no wrap or saturation.

Test Plan:
- Reset then read w=0..C_NUM_REGS-1 -> each returns 0x00000000, ack exactly one cycle after select, user_update never pulses.
- C_ATOMIC=0, write 0xDEADBEEF BE=1111 to w=2 -> user_data_out[95:64]=0xDEADBEEF, user_update=0x04 for one cycle; readback 0xDEADBEEF.
- Write 0x11223344 with BE=0101 over 0xDEADBEEF -> register = 0xDE22BE44.
- C_ATOMIC=1, write 0x5 to w=0 and 0x7 to w=1 -> user_data_out unchanged, readback shows 0x5/0x7; write 1 to w=C_NUM_REGS -> both outputs update same cycle, user_update=all-ones one cycle.
- Address C_HIGHADDR+4 with select held 3 cycles -> no ack, no change; read control word -> 0x00000802 for C_NUM_REGS=8, C_ATOMIC=1.
- Assert OPB_Rst=0 on the cycle a write hit is sampled -> no ack, all registers C_RESET_VAL after release.
